// File: rtl/wseq_pkg.sv
// rtl/wseq_pkg.sv - shared types and constants for the weight read sequencer
// Purpose: FSM state encoding, beat tag struct and word geometry used by the
//          sequencer top and its skid FIFO.
package wseq_pkg;

  localparam int WORD_W    = 576;  // one bank: 9 positions x 8 channels x 8 bits
  localparam int BANKS     = 8;    // filters per output group
  localparam int TAG_GRP_W = 8;    // og/ig counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wseq_state_e;

  typedef struct packed {
    logic [TAG_GRP_W-1:0] og;
    logic [TAG_GRP_W-1:0] ig;
    logic                 first;
    logic                 last;
  } wseq_tag_t;

endpackage

// File: rtl/wseq_skid_fifo.sv
// rtl/wseq_skid_fifo.sv - show-ahead skid FIFO holding weight words and their tags
// Purpose: buffers returned weight_manager words until the MAC array accepts them.
// Ports:
//   clk, rst_n           clock, async active-low reset (pointers/count only)
//   push, push_data/tag  write one entry; caller guarantees room via credits
//   pop                  consume head; caller guarantees count != 0
//   head_data/head_tag   current head entry (show-ahead)
//   count                number of stored entries
module wseq_skid_fifo
  import wseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [BANKS-1:0][WORD_W-1:0] push_data,
  input  wseq_tag_t                    push_tag,
  input  logic                         pop,
  output logic [BANKS-1:0][WORD_W-1:0] head_data,
  output wseq_tag_t                    head_tag,
  output logic [CNT_W-1:0]             count
);

  localparam int PW = $clog2(DEPTH);

  logic [BANKS-1:0][WORD_W-1:0] mem_data [DEPTH];
  wseq_tag_t                    mem_tag  [DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_tag[wr_ptr]  <= push_tag;
    end
  end

  assign head_data = mem_data[rd_ptr];
  assign head_tag  = mem_tag[rd_ptr];

endmodule

// File: rtl/weight_read_sequencer.sv
// rtl/weight_read_sequencer.sv - walks (og, rep, ig) and streams weight words to the MAC array
// Purpose: issues one weight_manager read per cycle under credit control, tracks
//          each read through a fixed-latency tag pipe and presents tagged words
//          over valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, cfg_*               job launch and geometry (sampled only when IDLE)
//   busy, done, err            job status; err sticky until next start
//   rd_en, rd_addr             weight_manager read port
//   wm_data, wm_data_ready     weight_manager return data
//   out_valid/ready/data       filter-group beat to the MAC array
//   out_og/ig/first/last       tag of the current beat
module weight_read_sequencer
  import wseq_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int GRP_W      = TAG_GRP_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
  input  logic [GRP_W-1:0]             cfg_ci_groups,
  input  logic [GRP_W-1:0]             cfg_co_groups,
  input  logic [GRP_W-1:0]             cfg_reps,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [BANKS-1:0][WORD_W-1:0] wm_data,
  input  logic                         wm_data_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BANKS-1:0][WORD_W-1:0] out_data,
  output logic [GRP_W-1:0]             out_og,
  output logic [GRP_W-1:0]             out_ig,
  output logic                         out_first,
  output logic                         out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  wseq_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] base_q, og_off_q;
  logic [GRP_W-1:0]      ci_q, co_q, reps_q;
  logic [GRP_W-1:0]      og_q, rep_q, ig_q;

  // Stage 0 is the cycle rd_en is high; data returns while the tag sits in the last stage.
  logic      pipe_v   [RD_LAT];
  wseq_tag_t pipe_tag [RD_LAT];

  logic            start_ok, in_issue, issue, pop, can_issue, drain_done;
  logic            last_ig, last_rep, last_og, last_issue, cfg_zero;
  logic [OCC_W-1:0] occ;
  wseq_tag_t       issue_tag, head_tag;
  logic [CNT_W-1:0] fifo_count;

  assign start_ok = start && (state == IDLE);
  assign cfg_zero = (cfg_ci_groups == '0) || (cfg_co_groups == '0) || (cfg_reps == '0);
  assign last_ig    = (ig_q  == ci_q   - GRP_W'(1));
  assign last_rep   = (rep_q == reps_q - GRP_W'(1));
  assign last_og    = (og_q  == co_q   - GRP_W'(1));
  assign last_issue = last_ig && last_rep && last_og;
  assign pop        = out_valid && out_ready;

  always_comb begin
    issue_tag.og    = og_q;
    issue_tag.ig    = ig_q;
    issue_tag.first = (ig_q == '0);
    issue_tag.last  = last_ig;
  end

  // Every read in the pipe will land in the FIFO, so they all hold a slot.
  // A pop this cycle frees one slot in time for the next read.
  always_comb begin
    occ = OCC_W'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) occ = occ + OCC_W'(pipe_v[i]);
  end
  assign can_issue  = occ < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
  assign drain_done = (occ == OCC_W'(pop));
  assign issue      = in_issue && can_issue;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = cfg_zero ? DONE : ISSUE;
      ISSUE:   if (issue && last_issue) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    in_issue = (state == ISSUE);
  end

  // Config latch, loop counters and the running og*ci offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      ci_q     <= '0;
      co_q     <= '0;
      reps_q   <= '0;
      og_q     <= '0;
      rep_q    <= '0;
      ig_q     <= '0;
      og_off_q <= '0;
      rd_addr  <= '0;
      err      <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q   <= cfg_base_addr;
        ci_q     <= cfg_ci_groups;
        co_q     <= cfg_co_groups;
        reps_q   <= cfg_reps;
        og_q     <= '0;
        rep_q    <= '0;
        ig_q     <= '0;
        og_off_q <= '0;
        err      <= 1'b0;
      end else if (pipe_v[RD_LAT-1] && !wm_data_ready) begin
        err <= 1'b1;
      end
      if (issue) begin
        rd_addr <= base_q + og_off_q + ADDR_WIDTH'(ig_q);
        if (!last_ig) begin
          ig_q <= ig_q + GRP_W'(1);
        end else begin
          ig_q <= '0;
          if (!last_rep) begin
            rep_q <= rep_q + GRP_W'(1);
          end else begin
            rep_q    <= '0;
            og_q     <= og_q + GRP_W'(1);
            og_off_q <= og_off_q + ADDR_WIDTH'(ci_q);
          end
        end
      end
    end
  end

  // Tag pipe shifts unconditionally: weight_manager has no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= issue;
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign rd_en = pipe_v[0];

  wseq_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_v[RD_LAT-1]),
    .push_data (wm_data),
    .push_tag  (pipe_tag[RD_LAT-1]),
    .pop       (pop),
    .head_data (out_data),
    .head_tag  (head_tag),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_og    = head_tag.og;
  assign out_ig    = head_tag.ig;
  assign out_first = head_tag.first;
  assign out_last  = head_tag.last;

endmodule

// File: tb/tb_weight_read_sequencer.sv
// tb/tb_weight_read_sequencer.sv - directed self-checking bench for weight_read_sequencer
module tb_weight_read_sequencer;

  localparam int AW = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        cfg_base_addr;
  logic [7:0]           cfg_ci_groups, cfg_co_groups, cfg_reps;
  logic                 busy, done, err, rd_en;
  logic [AW-1:0]        rd_addr;
  logic [7:0][575:0]    wm_data;
  logic                 wm_data_ready;
  logic                 out_valid, out_ready;
  logic [7:0][575:0]    out_data;
  logic [7:0]           out_og, out_ig;
  logic                 out_first, out_last;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  weight_read_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_ci_groups (cfg_ci_groups),
    .cfg_co_groups (cfg_co_groups),
    .cfg_reps      (cfg_reps),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .wm_data       (wm_data),
    .wm_data_ready (wm_data_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_og        (out_og),
    .out_ig        (out_ig),
    .out_first     (out_first),
    .out_last      (out_last)
  );

  // Word content is a pure function of address so any beat can be predicted.
  function automatic logic [7:0][575:0] wm_word(input logic [AW-1:0] a);
    logic [7:0][575:0] w;
    for (int b = 0; b < 8; b++) begin
      w[b] = '0;
      w[b][575:560] = {a, 4'(b)};
      w[b][15:0]    = ~{a, 4'(b)};
    end
    return w;
  endfunction

  // weight_manager stand-in: data returns while the tag is in the third pipe stage.
  logic          wm_v0 = 1'b0, wm_v1 = 1'b0;
  logic [AW-1:0] wm_a0 = '0, wm_a1 = '0;
  logic          drop_en = 1'b0;
  logic [AW-1:0] drop_addr = '0;

  always @(posedge clk) begin
    wm_v0 <= rd_en;
    wm_a0 <= rd_addr;
    wm_v1 <= wm_v0;
    wm_a1 <= wm_a0;
  end

  assign wm_data       = wm_word(wm_a1);
  assign wm_data_ready = wm_v1 && !(drop_en && (wm_a1 == drop_addr));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string name, input logic [AW-1:0] base, input logic [7:0] ci,
                         input logic [7:0] co, input logic [7:0] reps, input bit rnd,
                         input bit exp_err);
    logic [AW-1:0] ea[$];
    logic [7:0]    eog[$], eig[$];
    int total, nr, nb, ndone, done_cyc, first_rd, last_rd, max_out, busy_gap;
    bit fin;
    for (int og = 0; og < int'(co); og++)
      for (int rp = 0; rp < int'(reps); rp++)
        for (int ig = 0; ig < int'(ci); ig++) begin
          ea.push_back(base + AW'(og * int'(ci) + ig));
          eog.push_back(8'(og));
          eig.push_back(8'(ig));
        end
    total = ea.size();
    nr = 0; nb = 0; ndone = 0; done_cyc = -1; first_rd = -1; last_rd = -1;
    max_out = 0; busy_gap = 0; fin = 1'b0;

    @(posedge clk); #1;
    cfg_base_addr = base; cfg_ci_groups = ci; cfg_co_groups = co; cfg_reps = reps;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble cfg inputs after the accepted start; the job must not notice.
    cfg_base_addr = 12'h555; cfg_ci_groups = 8'd5; cfg_co_groups = 8'd3; cfg_reps = 8'd2;

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check({name, ":err_clear_at_start"}, err, 1'b0);
      if (rd_en) begin
        if (nr < total) check({name, ":rd_addr"}, rd_addr, ea[nr]);
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        nr++;
      end
      if (nr - nb > max_out) max_out = nr - nb;
      if (out_valid && out_ready) begin
        if (nb < total)
          check({name, ":beat"},
                {out_og, out_ig, out_first, out_last, (out_data === wm_word(ea[nb]))},
                {eog[nb], eig[nb], (eig[nb] == 8'd0), (eig[nb] == ci - 8'd1), 1'b1});
        nb++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1'b1;
        check({name, ":busy_with_done"}, busy, 1'b1);
      end else if (!busy) begin
        busy_gap++;
      end
      if (!fin) begin
        @(posedge clk); #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start = (rnd && cyc == 5);
      end
    end
    start = 1'b0;

    check({name, ":done_seen"}, ndone, 1);
    check({name, ":reads"}, nr, total);
    check({name, ":beats"}, nb, total);
    check({name, ":err"}, err, exp_err);
    check({name, ":outstanding_le4"}, (max_out <= 4), 1'b1);
    check({name, ":busy_held"}, busy_gap, 0);
    if (total == 0) check({name, ":done_latency"}, done_cyc, 0);
    else if (!rnd)  check({name, ":back_to_back"}, last_rd - first_rd, total - 1);
    @(negedge clk);
    check({name, ":idle_after_done"}, {busy, done, out_valid}, 3'b000);
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    cfg_base_addr = '0; cfg_ci_groups = '0; cfg_co_groups = '0; cfg_reps = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {busy, done, err, rd_en, out_valid, rd_addr}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 128 beats, addresses 0..127 back-to-back
    run_job("full", 12'd0, 8'd8, 8'd16, 8'd1, 1'b0, 1'b0);
    // weights re-streamed per tile: 0,1,0,1,0,1,2,3,2,3,2,3
    run_job("reps", 12'd0, 8'd2, 8'd2, 8'd3, 1'b0, 1'b0);
    // consumer back-pressure plus an ignored start mid-job
    run_job("rand", 12'd10, 8'd4, 8'd4, 8'd3, 1'b1, 1'b0);
    // address wrap: 4094,4095,0,1
    run_job("wrap", 12'd4094, 8'd2, 8'd2, 8'd1, 1'b0, 1'b0);
    // empty job
    run_job("zero", 12'd7, 8'd2, 8'd0, 8'd1, 1'b0, 1'b0);

    // reset in the middle of issuing
    @(posedge clk); #1;
    cfg_base_addr = 12'd0; cfg_ci_groups = 8'd8; cfg_co_groups = 8'd16; cfg_reps = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, err, rd_en, out_valid, rd_addr}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("held_reset", {busy, rd_en, out_valid}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job("post_rst", 12'd20, 8'd3, 8'd2, 8'd2, 1'b0, 1'b0);

    // one returned word without data_ready: sticky err, beat still delivered
    drop_en = 1'b1; drop_addr = 12'd101;
    run_job("err", 12'd100, 8'd2, 8'd2, 8'd1, 1'b0, 1'b1);
    drop_en = 1'b0;
    // next start clears err; single beat is both first and last
    run_job("clr", 12'd0, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
